// File: rtl/vanilla_trace_checker_if.sv
// Commit-tap and golden-record ports of the trace checker.
// The checker sits on the slave side; the core tap and trace loader drive the master side.
interface vanilla_trace_checker_if;
  logic        commit_v_i;
  logic [31:0] commit_pc_i;
  logic [1:0]  commit_kind_i;
  logic [4:0]  commit_rd_i;
  logic [31:0] commit_data_i;
  logic        golden_v_i;
  logic [31:0] golden_pc_i;
  logic [1:0]  golden_kind_i;
  logic [4:0]  golden_rd_i;
  logic [31:0] golden_data_i;
  logic        golden_last_i;
  logic        golden_ready_o;

  modport master (
    output commit_v_i, commit_pc_i, commit_kind_i, commit_rd_i, commit_data_i,
    output golden_v_i, golden_pc_i, golden_kind_i, golden_rd_i, golden_data_i, golden_last_i,
    input  golden_ready_o
  );

  modport slave (
    input  commit_v_i, commit_pc_i, commit_kind_i, commit_rd_i, commit_data_i,
    input  golden_v_i, golden_pc_i, golden_kind_i, golden_rd_i, golden_data_i, golden_last_i,
    output golden_ready_o
  );
endinterface

// File: rtl/vanilla_trace_checker.sv
// In-order checker of live core commits against a golden commit trace.
// Live commits are buffered in a FIFO; each golden record is compared against the FIFO head.
module vanilla_trace_checker #(
  parameter int fifo_els_p         = 8,
  parameter int count_width_p      = 32,
  parameter int halt_on_mismatch_p = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     en_i,
  vanilla_trace_checker_if.slave   tr,
  output logic [1:0]               state_o,
  output logic [count_width_p-1:0] match_count_o,
  output logic [count_width_p-1:0] mismatch_count_o,
  output logic [1:0]               error_o,
  output logic [count_width_p-1:0] err_idx_o,
  output logic [31:0]              err_live_pc_o,
  output logic [31:0]              err_golden_pc_o
);
  localparam int AW = $clog2(fifo_els_p);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(fifo_els_p);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [31:0] data;
  } rec_t;

  rec_t                     r_mem [fifo_els_p];
  logic [AW-1:0]            r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]            r_cnt;
  logic [1:0]               r_state;
  logic [count_width_p-1:0] r_match_cnt, r_mism_cnt, r_err_idx;
  logic [1:0]               r_err;
  logic [31:0]              r_err_lpc, r_err_gpc;

  rec_t                     w_in, w_head;
  logic                     w_run, w_empty, w_full, w_ready, w_fire, w_match, w_mism;
  logic                     w_push, w_ovf, w_halt_mm, w_to_halt, w_to_done, w_left, w_extra;
  logic [CW-1:0]            w_cnt_nxt, w_rest;
  logic [31:0]              w_nxt_head_pc;
  logic [count_width_p:0]   w_sum;
  logic [count_width_p-1:0] w_total;

  assign w_in    = '{pc: tr.commit_pc_i, kind: tr.commit_kind_i, rd: tr.commit_rd_i,
                     data: tr.commit_data_i};
  assign w_head  = r_mem[r_rd_ptr];
  assign w_run   = (r_state == ST_RUN);
  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == DEPTH);
  assign w_ready = w_run & ~w_empty;
  assign w_fire  = tr.golden_v_i & w_ready;

  // rd/data only matter when something is written; kind 3 never matches
  assign w_match = (w_head.pc == tr.golden_pc_i) && (w_head.kind == tr.golden_kind_i) &&
                   (tr.golden_kind_i != 2'd3) &&
                   ((tr.golden_kind_i == 2'd0) ||
                    ((w_head.rd == tr.golden_rd_i) && (w_head.data == tr.golden_data_i)));
  assign w_mism  = w_fire & ~w_match;

  // a pop in the same cycle frees a slot, so a full FIFO still accepts the push
  assign w_push    = w_run & tr.commit_v_i & (~w_full | w_fire);
  assign w_ovf     = w_run & tr.commit_v_i & w_full & ~w_fire;
  assign w_halt_mm = w_mism & (halt_on_mismatch_p != 0);
  assign w_to_halt = w_ovf | w_halt_mm;
  assign w_to_done = w_fire & tr.golden_last_i & ~w_to_halt;
  assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_fire);
  assign w_left    = w_to_done & (w_cnt_nxt != '0);
  assign w_extra   = (r_state == ST_DONE) & tr.commit_v_i;

  // PC of whatever sits at the head once this cycle's pop/push settle
  assign w_rest        = r_cnt - CW'(w_fire);
  assign w_nxt_head_pc = (w_rest != '0) ? r_mem[r_rd_ptr + AW'(w_fire)].pc : tr.commit_pc_i;

  assign w_sum   = {1'b0, r_match_cnt} + {1'b0, r_mism_cnt};
  assign w_total = w_sum[count_width_p] ? '1 : w_sum[count_width_p-1:0];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < fifo_els_p; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_in;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_cnt       <= '0;
      r_state     <= ST_IDLE;
      r_match_cnt <= '0;
      r_mism_cnt  <= '0;
      r_err       <= 2'd0;
      r_err_idx   <= '0;
      r_err_lpc   <= '0;
      r_err_gpc   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_fire) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_cnt <= w_cnt_nxt;

      if (w_fire &  w_match && r_match_cnt != '1) r_match_cnt <= r_match_cnt + count_width_p'(1);
      if (w_mism && r_mism_cnt != '1)             r_mism_cnt  <= r_mism_cnt + count_width_p'(1);

      case (r_state)
        ST_IDLE: if (en_i) r_state <= ST_RUN;
        ST_RUN: begin
          if (w_to_halt)      r_state <= ST_HALT;
          else if (w_to_done) r_state <= ST_DONE;
        end
        default: r_state <= r_state;
      endcase

      // first error wins; within a cycle mismatch outranks overflow outranks end-of-trace
      if (r_err == 2'd0) begin
        if (w_mism) begin
          r_err     <= 2'd1;
          r_err_idx <= w_total;
          r_err_lpc <= w_head.pc;
          r_err_gpc <= tr.golden_pc_i;
        end else if (w_ovf) begin
          r_err     <= 2'd2;
          r_err_idx <= w_total;
          r_err_lpc <= tr.commit_pc_i;
          r_err_gpc <= '0;
        end else if (w_left) begin
          r_err     <= 2'd3;
          r_err_idx <= w_total;
          r_err_lpc <= w_nxt_head_pc;
          r_err_gpc <= '0;
        end else if (w_extra) begin
          r_err     <= 2'd3;
          r_err_idx <= w_total;
          r_err_lpc <= tr.commit_pc_i;
          r_err_gpc <= '0;
        end
      end
    end
  end

  assign tr.golden_ready_o = w_ready;
  assign state_o           = r_state;
  assign match_count_o     = r_match_cnt;
  assign mismatch_count_o  = r_mism_cnt;
  assign error_o           = r_err;
  assign err_idx_o         = r_err_idx;
  assign err_live_pc_o     = r_err_lpc;
  assign err_golden_pc_o   = r_err_gpc;
endmodule

// File: tb/tb_vanilla_trace_checker.sv
// Directed bench: dut0 halts on mismatch, dut1 keeps counting; both see identical stimulus.
module tb_vanilla_trace_checker;
  logic clk = 1'b0;
  logic reset_ni;
  logic en_i;
  always #5 clk = ~clk;

  vanilla_trace_checker_if if0();
  vanilla_trace_checker_if if1();

  assign if1.commit_v_i    = if0.commit_v_i;
  assign if1.commit_pc_i   = if0.commit_pc_i;
  assign if1.commit_kind_i = if0.commit_kind_i;
  assign if1.commit_rd_i   = if0.commit_rd_i;
  assign if1.commit_data_i = if0.commit_data_i;
  assign if1.golden_v_i    = if0.golden_v_i;
  assign if1.golden_pc_i   = if0.golden_pc_i;
  assign if1.golden_kind_i = if0.golden_kind_i;
  assign if1.golden_rd_i   = if0.golden_rd_i;
  assign if1.golden_data_i = if0.golden_data_i;
  assign if1.golden_last_i = if0.golden_last_i;

  logic [1:0]  st0, st1, err0, err1;
  logic [31:0] mc0, mc1, mm0, mm1, idx0, idx1, lpc0, lpc1, gpc0, gpc1;

  vanilla_trace_checker #(.fifo_els_p(8), .count_width_p(32), .halt_on_mismatch_p(1)) u_dut0 (
    .clk_i(clk), .reset_ni(reset_ni), .en_i(en_i), .tr(if0.slave),
    .state_o(st0), .match_count_o(mc0), .mismatch_count_o(mm0), .error_o(err0),
    .err_idx_o(idx0), .err_live_pc_o(lpc0), .err_golden_pc_o(gpc0));

  vanilla_trace_checker #(.fifo_els_p(8), .count_width_p(32), .halt_on_mismatch_p(0)) u_dut1 (
    .clk_i(clk), .reset_ni(reset_ni), .en_i(en_i), .tr(if1.slave),
    .state_o(st1), .match_count_o(mc1), .mismatch_count_o(mm1), .error_o(err1),
    .err_idx_o(idx1), .err_live_pc_o(lpc1), .err_golden_pc_o(gpc1));

  int checks = 0;
  int errors = 0;

  logic [31:0] g_pc [6];
  logic [1:0]  g_k  [6];
  logic [4:0]  g_rd [6];
  logic [31:0] g_d  [6];
  logic [4:0]  l_rd [6];
  logic [31:0] l_d  [6];

  task automatic clear_inputs();
    en_i = 0;
    if0.commit_v_i = 0; if0.commit_pc_i = 0; if0.commit_kind_i = 0;
    if0.commit_rd_i = 0; if0.commit_data_i = 0;
    if0.golden_v_i = 0; if0.golden_pc_i = 0; if0.golden_kind_i = 0;
    if0.golden_rd_i = 0; if0.golden_data_i = 0; if0.golden_last_i = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_ni = 0;
    clear_inputs();
    @(negedge clk);
    reset_ni = 1;
  endtask

  task automatic start();
    en_i = 1;
    @(negedge clk);
    en_i = 0;
  endtask

  task automatic drive_commit(input logic [31:0] pc, input logic [1:0] k,
                              input logic [4:0] rd, input logic [31:0] d);
    if0.commit_v_i = 1; if0.commit_pc_i = pc; if0.commit_kind_i = k;
    if0.commit_rd_i = rd; if0.commit_data_i = d;
    @(negedge clk);
    if0.commit_v_i = 0;
  endtask

  task automatic drive_golden(input logic [31:0] pc, input logic [1:0] k,
                              input logic [4:0] rd, input logic [31:0] d, input logic last);
    if0.golden_v_i = 1; if0.golden_pc_i = pc; if0.golden_kind_i = k;
    if0.golden_rd_i = rd; if0.golden_data_i = d; if0.golden_last_i = last;
    @(negedge clk);
    if0.golden_v_i = 0; if0.golden_last_i = 0;
  endtask

  task automatic test_reset();
    reset_ni = 0;
    clear_inputs();
    #12;
    checks++; if (st0 !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d exp 0", st0); end
    checks++; if (mc0 !== 32'd0 || mm0 !== 32'd0) begin errors++; $display("FAIL rst_counts: got %0d/%0d exp 0/0", mc0, mm0); end
    checks++; if (err0 !== 2'd0 || idx0 !== 32'd0 || lpc0 !== 32'd0 || gpc0 !== 32'd0)
      begin errors++; $display("FAIL rst_err: got %0d %0h %0h %0h exp all 0", err0, idx0, lpc0, gpc0); end
    checks++; if (if0.golden_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b exp 0", if0.golden_ready_o); end
    @(negedge clk);
    reset_ni = 1;
    // a commit while IDLE must not be enqueued
    drive_commit(32'h0, 2'd1, 5'd5, 32'h11);
    start();
    checks++; if (st0 !== 2'd1) begin errors++; $display("FAIL idle_to_run: got %0d exp 1", st0); end
    checks++; if (if0.golden_ready_o !== 1'b0) begin errors++; $display("FAIL idle_ignore: ready got %b exp 0", if0.golden_ready_o); end
  endtask

  task automatic test_match();
    do_reset();
    start();
    for (int i = 0; i < 4; i++) drive_commit(g_pc[i], g_k[i], l_rd[i], l_d[i]);
    for (int i = 0; i < 4; i++) drive_golden(g_pc[i], g_k[i], g_rd[i], g_d[i], i == 3);
    checks++; if (mc0 !== 32'd4 || mm0 !== 32'd0) begin errors++; $display("FAIL match_counts: got %0d/%0d exp 4/0", mc0, mm0); end
    checks++; if (st0 !== 2'd3) begin errors++; $display("FAIL match_state: got %0d exp 3", st0); end
    checks++; if (err0 !== 2'd0) begin errors++; $display("FAIL match_err: got %0d exp 0", err0); end
    checks++; if (mc1 !== 32'd4 || st1 !== 2'd3) begin errors++; $display("FAIL match_nohalt: got %0d st %0d exp 4 st 3", mc1, st1); end
  endtask

  task automatic test_mismatch();
    do_reset();
    start();
    for (int i = 0; i < 6; i++) drive_commit(g_pc[i], g_k[i], l_rd[i], (i == 2) ? 32'h40000000 : l_d[i]);
    for (int i = 0; i < 6; i++) drive_golden(g_pc[i], g_k[i], g_rd[i], g_d[i], i == 5);
    checks++; if (st0 !== 2'd2) begin errors++; $display("FAIL mm_halt_state: got %0d exp 2", st0); end
    checks++; if (mc0 !== 32'd2 || mm0 !== 32'd1) begin errors++; $display("FAIL mm_halt_counts: got %0d/%0d exp 2/1", mc0, mm0); end
    checks++; if (err0 !== 2'd1 || idx0 !== 32'd2) begin errors++; $display("FAIL mm_halt_err: got code %0d idx %0d exp 1 idx 2", err0, idx0); end
    checks++; if (lpc0 !== 32'h8 || gpc0 !== 32'h8) begin errors++; $display("FAIL mm_halt_pcs: got %0h/%0h exp 8/8", lpc0, gpc0); end
    checks++; if (st1 !== 2'd3 || mc1 !== 32'd5 || mm1 !== 32'd1)
      begin errors++; $display("FAIL mm_cont: got st %0d %0d/%0d exp st 3 5/1", st1, mc1, mm1); end
    checks++; if (err1 !== 2'd1 || idx1 !== 32'd2 || lpc1 !== 32'h8 || gpc1 !== 32'h8)
      begin errors++; $display("FAIL mm_cont_err: got %0d idx %0d %0h/%0h exp 1 idx 2 8/8", err1, idx1, lpc1, gpc1); end
    drive_commit(32'h50, 2'd1, 5'd1, 32'h1);
    checks++; if (st0 !== 2'd2 || mc0 !== 32'd2 || if0.golden_ready_o !== 1'b0)
      begin errors++; $display("FAIL mm_halt_ignore: got st %0d mc %0d rdy %b exp 2 2 0", st0, mc0, if0.golden_ready_o); end
    checks++; if (err1 !== 2'd1 || st1 !== 2'd3 || if1.golden_ready_o !== 1'b0)
      begin errors++; $display("FAIL mm_cont_retain: got code %0d st %0d rdy %b exp 1 3 0", err1, st1, if1.golden_ready_o); end
  endtask

  task automatic test_overflow();
    do_reset();
    start();
    for (int i = 0; i < 8; i++) drive_commit(32'h100 + 32'(4 * i), 2'd1, 5'd1, 32'(i));
    checks++; if (st0 !== 2'd1 || err0 !== 2'd0) begin errors++; $display("FAIL ovf_full_ok: got st %0d err %0d exp 1 0", st0, err0); end
    drive_commit(32'h120, 2'd1, 5'd1, 32'h9);
    checks++; if (err0 !== 2'd2 || st0 !== 2'd2) begin errors++; $display("FAIL ovf_err: got code %0d st %0d exp 2 2", err0, st0); end
    checks++; if (lpc0 !== 32'h120 || gpc0 !== 32'h0) begin errors++; $display("FAIL ovf_pcs: got %0h/%0h exp 120/0", lpc0, gpc0); end
    checks++; if (err1 !== 2'd2 || st1 !== 2'd2) begin errors++; $display("FAIL ovf_nohalt: got code %0d st %0d exp 2 2", err1, st1); end
  endtask

  task automatic test_extra_commit();
    do_reset();
    start();
    drive_commit(g_pc[0], g_k[0], l_rd[0], l_d[0]);
    drive_golden(g_pc[0], g_k[0], g_rd[0], g_d[0], 1'b1);
    checks++; if (st0 !== 2'd3 || err0 !== 2'd0) begin errors++; $display("FAIL extra_done: got st %0d err %0d exp 3 0", st0, err0); end
    drive_commit(32'h40, 2'd1, 5'd3, 32'h3);
    checks++; if (err0 !== 2'd3 || lpc0 !== 32'h40 || st0 !== 2'd3)
      begin errors++; $display("FAIL extra_err: got code %0d pc %0h st %0d exp 3 40 3", err0, lpc0, st0); end
    // a record still queued when the last golden record is consumed
    do_reset();
    start();
    drive_commit(g_pc[0], g_k[0], l_rd[0], l_d[0]);
    drive_commit(g_pc[1], g_k[1], l_rd[1], l_d[1]);
    drive_golden(g_pc[0], g_k[0], g_rd[0], g_d[0], 1'b1);
    checks++; if (err0 !== 2'd3 || st0 !== 2'd3) begin errors++; $display("FAIL extra_left: got code %0d st %0d exp 3 3", err0, st0); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    start();
    for (int i = 0; i < 8; i++) drive_commit(32'h200 + 32'(4 * i), 2'd0, 5'd0, 32'h0);
    if0.golden_v_i = 1; if0.golden_pc_i = 32'h200; if0.golden_kind_i = 2'd0;
    if0.golden_rd_i = 0; if0.golden_data_i = 0; if0.golden_last_i = 0;
    drive_commit(32'h220, 2'd0, 5'd0, 32'h0);
    if0.golden_v_i = 0;
    checks++; if (err0 !== 2'd0 || st0 !== 2'd1 || mc0 !== 32'd1)
      begin errors++; $display("FAIL b2b_pushpop: got err %0d st %0d mc %0d exp 0 1 1", err0, st0, mc0); end
    // still holding 8 entries, so a lone commit must overflow
    drive_commit(32'h224, 2'd0, 5'd0, 32'h0);
    checks++; if (err0 !== 2'd2 || lpc0 !== 32'h224) begin errors++; $display("FAIL b2b_occupancy: got code %0d pc %0h exp 2 224", err0, lpc0); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start();
    for (int i = 0; i < 4; i++) drive_commit(g_pc[i], g_k[i], l_rd[i], l_d[i]);
    drive_golden(g_pc[0], g_k[0], g_rd[0], g_d[0], 1'b0);
    checks++; if (mc0 !== 32'd1 || if0.golden_ready_o !== 1'b1)
      begin errors++; $display("FAIL rmid_pre: got mc %0d rdy %b exp 1 1", mc0, if0.golden_ready_o); end
    reset_ni = 0;
    #1;
    checks++; if (st0 !== 2'd0 || mc0 !== 32'd0 || err0 !== 2'd0 || if0.golden_ready_o !== 1'b0)
      begin errors++; $display("FAIL rmid_async: got st %0d mc %0d err %0d rdy %b exp 0 0 0 0", st0, mc0, err0, if0.golden_ready_o); end
    @(negedge clk);
    reset_ni = 1;
    start();
    checks++; if (st0 !== 2'd1 || if0.golden_ready_o !== 1'b0)
      begin errors++; $display("FAIL rmid_fifo_clear: got st %0d rdy %b exp 1 0", st0, if0.golden_ready_o); end
  endtask

  initial begin
    g_pc = '{32'h0, 32'h4, 32'h8, 32'hc, 32'h10, 32'h14};
    g_k  = '{2'd1, 2'd0, 2'd2, 2'd1, 2'd1, 2'd1};
    g_rd = '{5'd5, 5'd0, 5'd2, 5'd0, 5'd3, 5'd4};
    g_d  = '{32'h11, 32'h0, 32'h3f800000, 32'h0, 32'h22, 32'h33};
    // live rd/data differ on the kind-0 record; they must be ignored
    l_rd = '{5'd5, 5'd7, 5'd2, 5'd0, 5'd3, 5'd4};
    l_d  = '{32'h11, 32'hdead, 32'h3f800000, 32'h0, 32'h22, 32'h33};
    test_reset();
    test_match();
    test_mismatch();
    test_overflow();
    test_extra_commit();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
